if_id_ex_pipe_ctrl: RTL and testbench
=====================================

// Module: if_id_ex_pipe_ctrl
// PURPOSE
//   Front-end pipeline state for the 5-stage RV32I core: the PC register, the IF/ID register
//   and the ID/EX register, all governed by the load-use hazard unit's stall/flush commands
//   and by taken-branch redirects from EX.
//   Returns the current rs1/rs2/rd/memRead fields to the hazard unit, closing the stall loop.
//   Keeps a saturating count of load-use bubbles for performance debug.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value after reset
//   CTRL_W    12             width of the decoded ID control bundle carried into EX
//   CNT_W     16             width of the bubble counter
// PORTS
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous active-low reset
//   stall_pc       in   1       hold PC (from hazard unit)
//   stall_if_id    in   1       hold IF/ID (from hazard unit)
//   flush_id_ex    in   1       load bubble into ID/EX (from hazard unit)
//   branch_taken   in   1       EX-stage redirect
//   branch_target  in   32      redirect PC
//   imem_instr     in   32      instruction fetched at pc
//   id_mem_read    in   1       decoded memRead of the instruction in ID
//   id_ctrl        in   CTRL_W  decoded control bundle of the instruction in ID
//   id_rs1_data    in   32      register-file read data, rs1
//   id_rs2_data    in   32      register-file read data, rs2
//   id_imm         in   32      decoded immediate
//   pc             out  32      fetch address
//   if_id_pc       out  32      PC of the instruction in ID
//   if_id_instr    out  32      instruction in ID
//   if_id_valid    out  1       ID holds a real instruction
//   if_id_rs1      out  5       if_id_instr[19:15], combinational
//   if_id_rs2      out  5       if_id_instr[24:20], combinational
//   id_ex_pc       out  32      PC of the instruction in EX
//   id_ex_rs1      out  5       rs1 index carried into EX
//   id_ex_rs2      out  5       rs2 index carried into EX
//   id_ex_rd       out  5       rd index carried into EX
//   id_ex_mem_read out  1       memRead of the instruction in EX
//   id_ex_ctrl     out  CTRL_W  control bundle in EX
//   id_ex_rs1_data out  32      rs1 data in EX
//   id_ex_rs2_data out  32      rs2 data in EX
//   id_ex_imm      out  32      immediate in EX
//   id_ex_valid    out  1       EX holds a real instruction
//   bubble_cnt     out  CNT_W   load-use bubbles inserted, saturating
// BEHAVIOUR
//   - rst_n low (async, immediate, including mid-stall): pc=RESET_PC; if_id_instr=32'h0000_0013 (NOP);
//     if_id_pc=0; if_id_valid=0; all id_ex_* outputs=0; id_ex_valid=0; bubble_cnt=0.
//   - All state updates on the rising edge of clk. Fetch-to-ID latency 1 cycle; ID-to-EX latency 1 cycle.
//   - Priority per edge: branch_taken > stall/flush > normal advance.
//   - branch_taken=1: pc<=branch_target; IF/ID<=NOP with valid=0; ID/EX<=bubble.
//     Applies regardless of the stall inputs in the same cycle, and bubble_cnt does not change.
//   - Otherwise each register obeys its own command independently:
//       pc   : stall_pc ? hold : pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
//       IF/ID: stall_if_id ? hold (pc, instr, valid) : {pc, imem_instr, valid=1}.
//       ID/EX: flush_id_ex ? bubble : load all id_* fields, if_id_rs1/rs2/rd (instr[11:7]),
//              if_id_pc, valid=if_id_valid.
//   - Bubble = id_ex_ctrl=0, id_ex_mem_read=0, id_ex_rd/rs1/rs2=0, data/imm/pc=0, valid=0.
//   - ID field rule: when if_id_valid=0, id_ex_mem_read, id_ex_ctrl and id_ex_rd load 0,
//     so a NOP or flushed slot can never trigger a hazard.
//   - bubble_cnt increments on each edge where flush_id_ex=1 and branch_taken=0, and holds at 2^CNT_W-1.
//   - Mismatched stall_pc and stall_if_id (one set, the other clear) are honoured as given; no cross-checking.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles -> pc=0, if_id_instr=0x00000013, valids=0, bubble_cnt=0.
//     Release rst_n; 3 edges -> pc=0x0C, if_id_pc=0x08.
//   2 Load-use: lw x10 sits in ID/EX (id_ex_rd=10, mem_read=1), add x1,x10,x2 sits in IF/ID.
//     Drive stall_pc=stall_if_id=flush_id_ex=1 for 1 edge -> pc and IF/ID held,
//     id_ex_valid=0, id_ex_rd=0, bubble_cnt=1. Next edge with no stall -> add in EX, id_ex_rs1=10.
//   3 Branch during stall: stall_*=1, flush_id_ex=1, branch_taken=1, target 0x100 ->
//     pc=0x100, if_id_valid=0, id_ex_valid=0, bubble_cnt unchanged.
//   4 Wrap: force pc=0xFFFFFFFC via branch, then no stall -> pc=0x00000000.
//   5 Async reset mid-stall: assert rst_n=0 between edges while stall_pc=1 ->
//     outputs reach reset values before the next edge.
//   6 Saturation (CNT_W=4): 20 flush_id_ex cycles -> bubble_cnt=15.

Source files
------------

// File: rtl/if_id_ex_pipe_ctrl_if.sv
// Bundle of hazard-unit commands, fetch/decode inputs and pipeline-register outputs
// exchanged between the front-end pipeline control block and the rest of the core.
interface if_id_ex_pipe_ctrl_if #(
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
);
    logic              stall_pc;
    logic              stall_if_id;
    logic              flush_id_ex;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic [31:0]       imem_instr;
    logic              id_mem_read;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       id_rs1_data;
    logic [31:0]       id_rs2_data;
    logic [31:0]       id_imm;

    logic [31:0]       pc;
    logic [31:0]       if_id_pc;
    logic [31:0]       if_id_instr;
    logic              if_id_valid;
    logic [4:0]        if_id_rs1;
    logic [4:0]        if_id_rs2;
    logic [31:0]       id_ex_pc;
    logic [4:0]        id_ex_rs1;
    logic [4:0]        id_ex_rs2;
    logic [4:0]        id_ex_rd;
    logic              id_ex_mem_read;
    logic [CTRL_W-1:0] id_ex_ctrl;
    logic [31:0]       id_ex_rs1_data;
    logic [31:0]       id_ex_rs2_data;
    logic [31:0]       id_ex_imm;
    logic              id_ex_valid;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output stall_pc, stall_if_id, flush_id_ex, branch_taken, branch_target,
               imem_instr, id_mem_read, id_ctrl, id_rs1_data, id_rs2_data, id_imm,
        input  pc, if_id_pc, if_id_instr, if_id_valid, if_id_rs1, if_id_rs2,
               id_ex_pc, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_mem_read, id_ex_ctrl,
               id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_valid, bubble_cnt
    );

    modport slave (
        input  stall_pc, stall_if_id, flush_id_ex, branch_taken, branch_target,
               imem_instr, id_mem_read, id_ctrl, id_rs1_data, id_rs2_data, id_imm,
        output pc, if_id_pc, if_id_instr, if_id_valid, if_id_rs1, if_id_rs2,
               id_ex_pc, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_mem_read, id_ex_ctrl,
               id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_valid, bubble_cnt
    );
endinterface

// File: rtl/if_id_ex_pipe_ctrl.sv
// PC, IF/ID and ID/EX registers of the RV32I front end, steered by hazard-unit
// stall/flush commands and EX branch redirects; counts load-use bubbles.
module if_id_ex_pipe_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 12,
    parameter int          CNT_W    = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    if_id_ex_pipe_ctrl_if.slave bus
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]       pc_q;
    logic [31:0]       if_id_pc_q;
    logic [31:0]       if_id_instr_q;
    logic              if_id_valid_q;
    logic [31:0]       id_ex_pc_q;
    logic [4:0]        id_ex_rs1_q;
    logic [4:0]        id_ex_rs2_q;
    logic [4:0]        id_ex_rd_q;
    logic              id_ex_mem_read_q;
    logic [CTRL_W-1:0] id_ex_ctrl_q;
    logic [31:0]       id_ex_rs1_data_q;
    logic [31:0]       id_ex_rs2_data_q;
    logic [31:0]       id_ex_imm_q;
    logic              id_ex_valid_q;
    logic [CNT_W-1:0]  bubble_cnt_q;

    logic [4:0]        if_id_rs1;
    logic [4:0]        if_id_rs2;
    logic [4:0]        if_id_rd;
    logic              bubble_now;

    assign if_id_rs1  = if_id_instr_q[19:15];
    assign if_id_rs2  = if_id_instr_q[24:20];
    assign if_id_rd   = if_id_instr_q[11:7];
    assign bubble_now = bus.flush_id_ex && !bus.branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (bus.branch_taken) begin
            pc_q <= bus.branch_target;
        end else if (!bus.stall_pc) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_pc_q    <= 32'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else if (bus.branch_taken) begin
            if_id_pc_q    <= 32'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else if (!bus.stall_if_id) begin
            if_id_pc_q    <= pc_q;
            if_id_instr_q <= bus.imem_instr;
            if_id_valid_q <= 1'b1;
        end
    end

    // Hazard-relevant fields are zeroed for an empty ID slot so a NOP never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_pc_q       <= 32'h0;
            id_ex_rs1_q      <= 5'd0;
            id_ex_rs2_q      <= 5'd0;
            id_ex_rd_q       <= 5'd0;
            id_ex_mem_read_q <= 1'b0;
            id_ex_ctrl_q     <= '0;
            id_ex_rs1_data_q <= 32'h0;
            id_ex_rs2_data_q <= 32'h0;
            id_ex_imm_q      <= 32'h0;
            id_ex_valid_q    <= 1'b0;
        end else if (bus.branch_taken || bus.flush_id_ex) begin
            id_ex_pc_q       <= 32'h0;
            id_ex_rs1_q      <= 5'd0;
            id_ex_rs2_q      <= 5'd0;
            id_ex_rd_q       <= 5'd0;
            id_ex_mem_read_q <= 1'b0;
            id_ex_ctrl_q     <= '0;
            id_ex_rs1_data_q <= 32'h0;
            id_ex_rs2_data_q <= 32'h0;
            id_ex_imm_q      <= 32'h0;
            id_ex_valid_q    <= 1'b0;
        end else begin
            id_ex_pc_q       <= if_id_pc_q;
            id_ex_rs1_q      <= if_id_rs1;
            id_ex_rs2_q      <= if_id_rs2;
            id_ex_rd_q       <= if_id_valid_q ? if_id_rd : 5'd0;
            id_ex_mem_read_q <= if_id_valid_q && bus.id_mem_read;
            id_ex_ctrl_q     <= if_id_valid_q ? bus.id_ctrl : '0;
            id_ex_rs1_data_q <= bus.id_rs1_data;
            id_ex_rs2_data_q <= bus.id_rs2_data;
            id_ex_imm_q      <= bus.id_imm;
            id_ex_valid_q    <= if_id_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else if (bubble_now && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.if_id_pc       = if_id_pc_q;
    assign bus.if_id_instr    = if_id_instr_q;
    assign bus.if_id_valid    = if_id_valid_q;
    assign bus.if_id_rs1      = if_id_rs1;
    assign bus.if_id_rs2      = if_id_rs2;
    assign bus.id_ex_pc       = id_ex_pc_q;
    assign bus.id_ex_rs1      = id_ex_rs1_q;
    assign bus.id_ex_rs2      = id_ex_rs2_q;
    assign bus.id_ex_rd       = id_ex_rd_q;
    assign bus.id_ex_mem_read = id_ex_mem_read_q;
    assign bus.id_ex_ctrl     = id_ex_ctrl_q;
    assign bus.id_ex_rs1_data = id_ex_rs1_data_q;
    assign bus.id_ex_rs2_data = id_ex_rs2_data_q;
    assign bus.id_ex_imm      = id_ex_imm_q;
    assign bus.id_ex_valid    = id_ex_valid_q;
    assign bus.bubble_cnt     = bubble_cnt_q;
endmodule

// File: tb/tb_if_id_ex_pipe_ctrl.sv
// Directed bench for if_id_ex_pipe_ctrl: a stage-level reference model checked every
// cycle, plus hand-computed checkpoints for the load-use, branch, wrap and reset cases.
module tb_if_id_ex_pipe_ctrl;
    localparam int CTRL_W  = 12;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LW_X10  = 32'h0002_A503;
    localparam logic [31:0] ADD_X1  = 32'h0025_00B3;
    localparam logic [31:0] ADDI_X1 = 32'h0010_0093;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    if_id_ex_pipe_ctrl_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    if_id_ex_pipe_ctrl #(.RESET_PC(32'h0), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              mem_read;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       d1;
        logic [31:0]       d2;
        logic [31:0]       imm;
        logic              valid;
    } idex_t;

    logic [31:0] m_pc;
    ifid_t       m_ifid;
    idex_t       m_idex;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each stage's next content computed from the previous model contents.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc   = 32'h0;
            m_ifid = '{pc: 32'h0, instr: NOP, valid: 1'b0};
            m_idex = '0;
            m_cnt  = 0;
        end else if (bus.branch_taken) begin
            m_idex = '0;
            m_ifid = '{pc: 32'h0, instr: NOP, valid: 1'b0};
            m_pc   = bus.branch_target;
        end else begin
            if (bus.flush_id_ex) begin
                m_idex = '0;
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end else begin
                m_idex.pc       = m_ifid.pc;
                m_idex.rs1      = m_ifid.instr[19:15];
                m_idex.rs2      = m_ifid.instr[24:20];
                m_idex.rd       = m_ifid.valid ? m_ifid.instr[11:7] : 5'd0;
                m_idex.mem_read = m_ifid.valid ? bus.id_mem_read : 1'b0;
                m_idex.ctrl     = m_ifid.valid ? bus.id_ctrl : '0;
                m_idex.d1       = bus.id_rs1_data;
                m_idex.d2       = bus.id_rs2_data;
                m_idex.imm      = bus.id_imm;
                m_idex.valid    = m_ifid.valid;
            end
            if (!bus.stall_if_id) m_ifid = '{pc: m_pc, instr: bus.imem_instr, valid: 1'b1};
            if (!bus.stall_pc) m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
    end

    always @(negedge clk) begin
        chk("pc", bus.pc, m_pc);
        chk("if_id_pc", bus.if_id_pc, m_ifid.pc);
        chk("if_id_instr", bus.if_id_instr, m_ifid.instr);
        chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_ifid.valid));
        chk("if_id_rs1", 32'(bus.if_id_rs1), 32'(m_ifid.instr[19:15]));
        chk("if_id_rs2", 32'(bus.if_id_rs2), 32'(m_ifid.instr[24:20]));
        chk("id_ex_pc", bus.id_ex_pc, m_idex.pc);
        chk("id_ex_rs1", 32'(bus.id_ex_rs1), 32'(m_idex.rs1));
        chk("id_ex_rs2", 32'(bus.id_ex_rs2), 32'(m_idex.rs2));
        chk("id_ex_rd", 32'(bus.id_ex_rd), 32'(m_idex.rd));
        chk("id_ex_mem_read", 32'(bus.id_ex_mem_read), 32'(m_idex.mem_read));
        chk("id_ex_ctrl", 32'(bus.id_ex_ctrl), 32'(m_idex.ctrl));
        chk("id_ex_rs1_data", bus.id_ex_rs1_data, m_idex.d1);
        chk("id_ex_rs2_data", bus.id_ex_rs2_data, m_idex.d2);
        chk("id_ex_imm", bus.id_ex_imm, m_idex.imm);
        chk("id_ex_valid", 32'(bus.id_ex_valid), 32'(m_idex.valid));
        chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cmd(input logic sp, input logic sif, input logic fl,
                       input logic br, input logic [31:0] tgt);
        bus.stall_pc      = sp;
        bus.stall_if_id   = sif;
        bus.flush_id_ex   = fl;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
    endtask

    initial begin
        cmd(0, 0, 0, 0, 32'h0);
        bus.imem_instr  = NOP;
        bus.id_mem_read = 1'b0;
        bus.id_ctrl     = '0;
        bus.id_rs1_data = 32'h0;
        bus.id_rs2_data = 32'h0;
        bus.id_imm      = 32'h0;

        repeat (2) step();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_instr", bus.if_id_instr, 32'h0000_0013);
        chk("rst_if_id_valid", 32'(bus.if_id_valid), 32'h0);
        chk("rst_id_ex_valid", 32'(bus.id_ex_valid), 32'h0);
        chk("rst_cnt", 32'(bus.bubble_cnt), 32'h0);

        rst_n = 1'b1;
        bus.imem_instr = ADDI_X1;
        repeat (3) step();
        chk("run_pc", bus.pc, 32'h0000_000C);
        chk("run_if_id_pc", bus.if_id_pc, 32'h0000_0008);

        bus.imem_instr = LW_X10;
        step();
        bus.imem_instr  = ADD_X1;
        bus.id_mem_read = 1'b1;
        bus.id_ctrl     = 12'h0A5;
        bus.id_rs1_data = 32'h0000_1000;
        bus.id_imm      = 32'h0000_0004;
        step();
        chk("lw_rd", 32'(bus.id_ex_rd), 32'd10);
        chk("lw_mem_read", 32'(bus.id_ex_mem_read), 32'd1);
        chk("add_rs1", 32'(bus.if_id_rs1), 32'd10);
        chk("add_rs2", 32'(bus.if_id_rs2), 32'd2);

        cmd(1, 1, 1, 0, 32'h0);
        bus.id_mem_read = 1'b0;
        bus.id_ctrl     = 12'h033;
        bus.id_rs1_data = 32'h0000_0022;
        bus.id_rs2_data = 32'h0000_0044;
        bus.id_imm      = 32'h0;
        bus.imem_instr  = 32'hDEAD_BEEF;
        step();
        chk("stall_pc", bus.pc, 32'h0000_0014);
        chk("stall_if_id_pc", bus.if_id_pc, 32'h0000_0010);
        chk("stall_if_id_instr", bus.if_id_instr, ADD_X1);
        chk("bubble_valid", 32'(bus.id_ex_valid), 32'h0);
        chk("bubble_rd", 32'(bus.id_ex_rd), 32'h0);
        chk("bubble_cnt1", 32'(bus.bubble_cnt), 32'd1);

        cmd(0, 0, 0, 0, 32'h0);
        step();
        chk("add_ex_rs1", 32'(bus.id_ex_rs1), 32'd10);
        chk("add_ex_rd", 32'(bus.id_ex_rd), 32'd1);
        chk("add_ex_pc", bus.id_ex_pc, 32'h0000_0010);
        chk("add_ex_ctrl", 32'(bus.id_ex_ctrl), 32'h033);
        chk("add_ex_valid", 32'(bus.id_ex_valid), 32'd1);
        chk("add_pc", bus.pc, 32'h0000_0018);

        cmd(1, 1, 1, 1, 32'h0000_0100);
        step();
        chk("br_pc", bus.pc, 32'h0000_0100);
        chk("br_if_id_valid", 32'(bus.if_id_valid), 32'h0);
        chk("br_if_id_instr", bus.if_id_instr, NOP);
        chk("br_id_ex_valid", 32'(bus.id_ex_valid), 32'h0);
        chk("br_cnt", 32'(bus.bubble_cnt), 32'd1);

        cmd(0, 0, 0, 1, 32'hFFFF_FFFC);
        step();
        chk("wrap_pre", bus.pc, 32'hFFFF_FFFC);
        cmd(0, 0, 0, 0, 32'h0);
        bus.id_ctrl     = 12'hFFF;
        bus.id_mem_read = 1'b1;
        bus.imem_instr  = LW_X10;
        step();
        chk("wrap_pc", bus.pc, 32'h0000_0000);
        chk("wrap_if_id_pc", bus.if_id_pc, 32'hFFFF_FFFC);
        chk("empty_ctrl", 32'(bus.id_ex_ctrl), 32'h0);
        chk("empty_mem_read", 32'(bus.id_ex_mem_read), 32'h0);
        chk("empty_valid", 32'(bus.id_ex_valid), 32'h0);

        // Mismatched and partial command combinations, checked by the per-cycle model.
        for (int i = 0; i < 8; i++) begin
            cmd(i[0], i[1], i[2], 1'b0, 32'h0);
            bus.imem_instr  = 32'h0040_0513 + (32'(i) << 20);
            bus.id_rs1_data = 32'h1111_0000 + 32'(i);
            bus.id_rs2_data = 32'h2222_0000 + 32'(i);
            bus.id_imm      = 32'h3333_0000 + 32'(i);
            bus.id_ctrl     = 12'(12'h100 + i);
            bus.id_mem_read = i[0];
            step();
        end

        cmd(1, 0, 0, 0, 32'h0);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("async_pc", bus.pc, 32'h0);
        chk("async_instr", bus.if_id_instr, NOP);
        chk("async_if_id_valid", 32'(bus.if_id_valid), 32'h0);
        chk("async_id_ex_valid", 32'(bus.id_ex_valid), 32'h0);
        chk("async_cnt", 32'(bus.bubble_cnt), 32'h0);
        step();
        rst_n = 1'b1;

        cmd(0, 0, 1, 0, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk("sat_cnt14", 32'(bus.bubble_cnt), 32'd14);
        end
        chk("sat_cnt20", 32'(bus.bubble_cnt), 32'd15);

        cmd(0, 0, 0, 0, 32'h0);
        step();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
